serial_magnitude_comparator: RTL
================================

// Module: serial_magnitude_comparator
// PURPOSE
//   Parametrised, bit-serial magnitude comparator; successor to the 2-bit combinational
//   greater-than comparator. Latches two WIDTH-bit operands on a start handshake.
//   Scans them MSB-first, one bit per clock, in unsigned or two's-complement mode.
//   Reports gt/eq/lt with a one-cycle done pulse. Targets wide operands where area matters more than latency.
// PARAMETERS
//   WIDTH       8   operand width in bits; legal range >= 1
//   EARLY_EXIT  1   1: stop at first differing bit; 0: always scan all WIDTH bits (fixed latency)
//   CNT_W       $clog2(WIDTH+1)   width of bits_scanned; derived, not overridden
// PORTS
//   clk           in   1      rising-edge clock
//   rst_n         in   1      synchronous reset, active-low
//   start         in   1      request; sampled only when busy=0
//   signed_mode   in   1      0 unsigned, 1 two's complement; latched with operands
//   a             in   WIDTH  operand A; latched on accepted start
//   b             in   WIDTH  operand B; latched on accepted start
//   busy          out  1      high while a comparison is in progress
//   done          out  1      one-cycle pulse; gt/eq/lt/bits_scanned valid from this cycle
//   gt            out  1      A > B
//   eq            out  1      A == B
//   lt            out  1      A < B
//   bits_scanned  out  CNT_W  number of bit positions examined for the last result
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state IDLE. busy, done, gt, eq, lt = 0. bits_scanned = 0.
//     Reset applied mid-scan aborts the scan; no done pulse follows.
//   FSM has two states: IDLE and SCAN.
//     IDLE -> SCAN on start=1. At that edge E0: latch a, b and signed_mode; idx = WIDTH-1; busy=1.
//     In SCAN, each clock compares bit idx of A and B.
//       Differing bit, idx = WIDTH-1, signed_mode=1: the operand with bit=1 is smaller.
//       Differing bit in every other case: the operand with bit=1 is larger.
//       Equal bit: idx decrements.
//     SCAN -> IDLE at edge En, where n = number of bits examined (1..WIDTH).
//       EARLY_EXIT=1: n = position of first difference counted from the MSB, else WIDTH.
//       EARLY_EXIT=0: n = WIDTH always. The first difference is kept; later bits are ignored.
//       At En: done=1, busy=0, exactly one of gt/eq/lt = 1, bits_scanned = n.
//       eq=1 only if no bit differed after all WIDTH bits.
//   Latency: done is high in the cycle following edge En, i.e. n clocks after acceptance.
//   done drops at E(n+1). gt/eq/lt/bits_scanned hold until the next accepted start edge,
//     where they clear to 0.
//   start while busy=1 is ignored; there is no queueing.
//   start is accepted at E(n+1), in the same cycle done=1 is visible. Back-to-back throughput = n+1 clocks.
//   a, b and signed_mode may change freely after acceptance; only latched copies are used.
//   WIDTH=1: one SCAN cycle. Signed mode treats 1 as -1 (a=1, b=0 gives lt).
//   idx never wraps. Leaving SCAN at idx=0 is mandatory; the counter saturates.
// STRUCTURE
//   Shared package cmp_pkg:
//     state typedef {IDLE, SCAN}.
//     localparam result codes RES_LT=2'b00, RES_EQ=2'b01, RES_GT=2'b10.
//     Same codes are reused by the bench scoreboard.
//   Single file with operand shift registers (left shift, MSB-first), idx counter and FSM.
//   Optional combinational sub-module cmp_bit_step: inputs (a_bit, b_bit, is_msb, signed_mode),
//     outputs (differ, a_larger). This is the only logic worth factoring out.
// TESTING  (WIDTH=8 unless noted; E0 = acceptance edge)
//   1. a=8'h00, b=8'h00, unsigned, EARLY_EXIT=1
//      -> done in cycle after E8; eq=1, gt=lt=0; bits_scanned=8.
//   2. a=8'h80, b=8'h7F, unsigned, EARLY_EXIT=1
//      -> done after E1; gt=1; bits_scanned=1. Same inputs with signed_mode=1 -> lt=1.
//   3. a=8'h05, b=8'h04, EARLY_EXIT=0; then a=8'h85, b=8'h04
//      -> gt=1 after E8 both times. Second run reports bits_scanned=8, not 1.
//   4. Assert start again at E2 during a scan -> ignored; result unchanged.
//      Then assert start while done=1 -> accepted; done/gt/eq/lt clear at that edge.
//   5. Hold rst_n=0 for one edge at E3 of a scan -> busy=0, all outputs 0 after that edge.
//      No done pulse follows; a new start then completes normally.
//   6. WIDTH=2, both modes, all 16 (a,b) pairs -> gt/eq/lt match $unsigned/$signed compare.
//      Unsigned gt matches the legacy 2-bit comparator outputs.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and result codes for the bit-serial magnitude comparator and its bench.
package cmp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [1:0] RES_LT = 2'b00;
   localparam logic [1:0] RES_EQ = 2'b01;
   localparam logic [1:0] RES_GT = 2'b10;

   // Result code for a differing bit, given which operand that bit makes larger.
   function automatic logic [1:0] diff_code(input logic a_larger);
      return a_larger ? RES_GT : RES_LT;
   endfunction

endpackage

// File: rtl/cmp_bit_step.sv
// One bit-position step of the MSB-first compare: does this bit differ, and does it favour A.
module cmp_bit_step (
   input  logic a_bit,
   input  logic b_bit,
   input  logic is_msb,
   input  logic signed_mode,
   output logic differ,
   output logic a_larger
);

   assign differ = a_bit ^ b_bit;

   // A two's-complement sign bit carries negative weight, so a 1 there marks the smaller operand.
   assign a_larger = differ & ((is_msb & signed_mode) ? b_bit : a_bit);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: latches A/B on start, scans MSB-first one bit per clock,
// and reports gt/eq/lt with a one-cycle done pulse.
module serial_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  bit EARLY_EXIT = 1'b1,
   localparam int CNT_W      = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [CNT_W-1:0] bits_scanned
);

   localparam logic [CNT_W-1:0] MSB_IDX = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, a_sh_next;
   logic [WIDTH-1:0] b_sh, b_sh_next;
   logic             signed_q, signed_next;
   logic [CNT_W-1:0] idx, idx_next;
   logic             found, found_next;
   logic             a_larger_q, a_larger_next;
   logic             res_valid, res_valid_next;
   logic [1:0]       res, res_next;
   logic [CNT_W-1:0] bits_q, bits_next;
   logic             done_q, done_next;

   logic             step_differ;
   logic             step_a_larger;
   logic             is_msb;
   logic             last_bit;

   assign is_msb   = (idx == MSB_IDX);
   assign last_bit = (idx == '0);

   cmp_bit_step u_step (
      .a_bit       (a_sh[WIDTH-1]),
      .b_bit       (b_sh[WIDTH-1]),
      .is_msb      (is_msb),
      .signed_mode (signed_q),
      .differ      (step_differ),
      .a_larger    (step_a_larger)
   );

   always_comb begin
      state_next     = state;
      a_sh_next      = a_sh;
      b_sh_next      = b_sh;
      signed_next    = signed_q;
      idx_next       = idx;
      found_next     = found;
      a_larger_next  = a_larger_q;
      res_valid_next = res_valid;
      res_next       = res;
      bits_next      = bits_q;
      done_next      = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_next     = SCAN;
               a_sh_next      = a;
               b_sh_next      = b;
               signed_next    = signed_mode;
               idx_next       = MSB_IDX;
               found_next     = 1'b0;
               a_larger_next  = 1'b0;
               res_valid_next = 1'b0;
               res_next       = RES_EQ;
               bits_next      = '0;
            end
         end

         SCAN: begin
            a_sh_next = a_sh << 1;
            b_sh_next = b_sh << 1;

            // Only the first (most significant) difference decides the result.
            if (step_differ && !found) begin
               found_next    = 1'b1;
               a_larger_next = step_a_larger;
            end

            if ((step_differ && EARLY_EXIT) || last_bit) begin
               state_next     = IDLE;
               done_next      = 1'b1;
               res_valid_next = 1'b1;
               bits_next      = WIDTH_C - idx;
               if (found) begin
                  res_next = diff_code(a_larger_q);
               end else if (step_differ) begin
                  res_next = diff_code(step_a_larger);
               end else begin
                  res_next = RES_EQ;
               end
            end else begin
               idx_next = idx - 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         signed_q   <= 1'b0;
         idx        <= '0;
         found      <= 1'b0;
         a_larger_q <= 1'b0;
         res_valid  <= 1'b0;
         res        <= RES_EQ;
         bits_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_next;
         a_sh       <= a_sh_next;
         b_sh       <= b_sh_next;
         signed_q   <= signed_next;
         idx        <= idx_next;
         found      <= found_next;
         a_larger_q <= a_larger_next;
         res_valid  <= res_valid_next;
         res        <= res_next;
         bits_q     <= bits_next;
         done_q     <= done_next;
      end
   end

   assign busy         = (state == SCAN);
   assign done         = done_q;
   assign gt           = res_valid && (res == RES_GT);
   assign eq           = res_valid && (res == RES_EQ);
   assign lt           = res_valid && (res == RES_LT);
   assign bits_scanned = bits_q;

endmodule
